// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet controller.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_BODY,
    ST_EOP_WAIT,
    ST_ERR_WAIT
  } state_e;

  // Encodings match pid[1:0] so the accepted PID maps straight onto pkt_type.
  typedef enum logic [1:0] {
    PKT_SPECIAL   = 2'd0,
    PKT_TOKEN     = 2'd1,
    PKT_HANDSHAKE = 2'd2,
    PKT_DATA      = 2'd3
  } pkt_type_e;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_SYNC        = 3'd1,
    ERR_PID         = 3'd2,
    ERR_CRC         = 3'd3,
    ERR_ALIGN       = 3'd4,
    ERR_OVERFLOW    = 3'd5,
    ERR_TIMEOUT     = 3'd6,
    ERR_UNSUPPORTED = 3'd7
  } err_code_e;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_SEED      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_SEED     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [7:0]  SYNC_DEFAULT   = 8'b1000_0000;

  function automatic logic pid_check(input logic [7:0] p);
    return p[7:4] == ~p[3:0];
  endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Bit-serial CRC (MSB feedback, fed LSB-first data) with a residual check.
module usb_crc_serial #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = '0,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] crc,
  output logic             residual_ok
);

  // The residual is what a zero register reaches after WIDTH ones, independent of payload.
  function automatic logic [WIDTH-1:0] calc_residual();
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      r = {r[WIDTH-2:0], 1'b0} ^ (r[WIDTH-1] ? '0 : POLY);
    return r;
  endfunction

  localparam logic [WIDTH-1:0] RESIDUAL = calc_residual();

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr)
      crc <= SEED;
    else if (en)
      crc <= {crc[WIDTH-2:0], 1'b0} ^ ((crc[WIDTH-1] ^ bit_in) ? POLY : '0);
  end

  assign residual_ok = (crc == RESIDUAL);

endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet controller: PID decode, body byte streaming, CRC5/CRC16
// residual checks and per-packet status with an inactivity timeout.
module usb_rx_pkt_ctrl
  import usb_rx_pkg::*;
#(
  parameter int          MAX_DATA_BYTES = 8,
  parameter logic [7:0]  SYNC_PATTERN   = SYNC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter bit          CHECK_CRC      = 1'b1,
  localparam int         CNT_W          = $clog2(MAX_DATA_BYTES + 3)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             eop,
  input  logic             shift_en,
  input  logic             rcv_bit,
  output logic [7:0]       rx_byte,
  output logic             rx_byte_valid,
  output logic [CNT_W-1:0] rx_byte_cnt,
  output logic [3:0]       pid,
  output logic [1:0]       pkt_type,
  output logic             rcving,
  output logic             pkt_done,
  output logic             pkt_ok,
  output logic [2:0]       err_code
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DATA_BYTES + 2);

  state_e           state;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic       in_rx, take_bit, byte_done, tmo_active, timeout, is_token;
  logic [7:0] byte_w;
  logic [4:0] crc5;
  logic [15:0] crc16;
  logic       crc5_res_ok, crc16_res_ok, crc5_ok, crc16_ok;

  assign in_rx      = (state == ST_SYNC) || (state == ST_PID) || (state == ST_BODY);
  assign take_bit   = shift_en && !eop && in_rx;
  assign byte_w     = {rcv_bit, shreg[7:1]};
  assign byte_done  = take_bit && (bit_cnt == 3'd7);
  assign tmo_active = in_rx || (state == ST_EOP_WAIT);
  assign timeout    = tmo_active && !shift_en && !eop && (tmo_cnt == TMO_LAST);
  assign is_token   = (pkt_type == PKT_TOKEN);

  usb_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .SEED(CRC5_SEED)) u_crc5 (
    .clk         (clk),
    .rst         (rst),
    .clr         (state == ST_IDLE),
    .en          (take_bit && (state == ST_BODY) && is_token),
    .bit_in      (rcv_bit),
    .crc         (crc5),
    .residual_ok (crc5_res_ok)
  );

  usb_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .SEED(CRC16_SEED)) u_crc16 (
    .clk         (clk),
    .rst         (rst),
    .clr         (state == ST_IDLE),
    .en          (take_bit && (state == ST_BODY) && !is_token),
    .bit_in      (rcv_bit),
    .crc         (crc16),
    .residual_ok (crc16_res_ok)
  );

  // The package residual pins the one the CRC block derives from its polynomial.
  assign crc5_ok  = crc5_res_ok  && (crc5  == CRC5_RESIDUAL);
  assign crc16_ok = crc16_res_ok && (crc16 == CRC16_RESIDUAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      shreg         <= '0;
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      rx_byte_cnt   <= '0;
      pid           <= '0;
      pkt_type      <= '0;
      rcving        <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_ok        <= 1'b0;
      err_code      <= '0;
    end else begin
      rx_byte_valid <= 1'b0;
      pkt_done      <= 1'b0;

      if (take_bit) begin
        shreg   <= byte_w;
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (shift_en || !tmo_active) tmo_cnt <= '0;
      else                         tmo_cnt <= tmo_cnt + 1'b1;

      if (timeout) begin
        pkt_done <= 1'b1;
        pkt_ok   <= 1'b0;
        err_code <= ERR_TIMEOUT;
        rcving   <= 1'b0;
        state    <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (d_edge) begin
            state       <= ST_SYNC;
            rcving      <= 1'b1;
            shreg       <= '0;
            bit_cnt     <= '0;
            rx_byte_cnt <= '0;
          end

          ST_SYNC: begin
            if (eop) begin
              pkt_done <= 1'b1; pkt_ok <= 1'b0; err_code <= ERR_ALIGN;
              rcving   <= 1'b0; state  <= ST_IDLE;
            end else if (byte_done) begin
              if (byte_w == SYNC_PATTERN) state <= ST_PID;
              else begin
                pkt_done <= 1'b1; pkt_ok <= 1'b0; err_code <= ERR_SYNC;
                rcving   <= 1'b0; state  <= ST_ERR_WAIT;
              end
            end
          end

          ST_PID: begin
            if (eop) begin
              pkt_done <= 1'b1; pkt_ok <= 1'b0; err_code <= ERR_ALIGN;
              rcving   <= 1'b0; state  <= ST_IDLE;
            end else if (byte_done) begin
              if (!pid_check(byte_w) || byte_w[1:0] == PKT_SPECIAL) begin
                pkt_done <= 1'b1; pkt_ok <= 1'b0;
                err_code <= pid_check(byte_w) ? ERR_UNSUPPORTED : ERR_PID;
                rcving   <= 1'b0; state  <= ST_ERR_WAIT;
              end else begin
                pid      <= byte_w[3:0];
                pkt_type <= byte_w[1:0];
                if (byte_w[1:0] == PKT_HANDSHAKE) begin
                  rcving <= 1'b0;
                  state  <= ST_EOP_WAIT;
                end else begin
                  state  <= ST_BODY;
                end
              end
            end
          end

          ST_BODY: begin
            if (eop) begin
              pkt_done <= 1'b1;
              rcving   <= 1'b0;
              state    <= ST_IDLE;
              if (is_token || bit_cnt != 3'd0 || rx_byte_cnt < CNT_W'(2)) begin
                pkt_ok <= 1'b0; err_code <= ERR_ALIGN;
              end else if (CHECK_CRC && !crc16_ok) begin
                pkt_ok <= 1'b0; err_code <= ERR_CRC;
              end else begin
                pkt_ok <= 1'b1; err_code <= ERR_NONE;
              end
            end else if (byte_done) begin
              if (!is_token && rx_byte_cnt == CNT_MAX) begin
                pkt_done <= 1'b1; pkt_ok <= 1'b0; err_code <= ERR_OVERFLOW;
                rcving   <= 1'b0; state  <= ST_ERR_WAIT;
              end else begin
                rx_byte       <= byte_w;
                rx_byte_valid <= 1'b1;
                rx_byte_cnt   <= rx_byte_cnt + 1'b1;
                // Second token byte completes addr/endp/CRC5.
                if (is_token && rx_byte_cnt == CNT_W'(1)) begin
                  rcving <= 1'b0;
                  state  <= ST_EOP_WAIT;
                end
              end
            end
          end

          ST_EOP_WAIT: begin
            if (eop) begin
              pkt_done <= 1'b1;
              state    <= ST_IDLE;
              if (CHECK_CRC && is_token && !crc5_ok) begin
                pkt_ok <= 1'b0; err_code <= ERR_CRC;
              end else begin
                pkt_ok <= 1'b1; err_code <= ERR_NONE;
              end
            end else if (shift_en) begin
              pkt_done <= 1'b1; pkt_ok <= 1'b0; err_code <= ERR_ALIGN;
              state    <= ST_ERR_WAIT;
            end
          end

          ST_ERR_WAIT: if (eop) state <= ST_IDLE;

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Scoreboard bench for usb_rx_pkt_ctrl: directed packets, queued expectations, decoupled monitor.
module tb_usb_rx_pkt_ctrl;

  logic       clk = 1'b0;
  logic       rst, d_edge, eop, shift_en, rcv_bit;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic [3:0] rx_byte_cnt;
  logic [3:0] pid;
  logic [1:0] pkt_type;
  logic       rcving, pkt_done, pkt_ok;
  logic [2:0] err_code;

  always #5 clk = ~clk;

  usb_rx_pkt_ctrl #(
    .MAX_DATA_BYTES (8),
    .SYNC_PATTERN   (8'b1000_0000),
    .TIMEOUT_CYCLES (256),
    .CHECK_CRC      (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .d_edge        (d_edge),
    .eop           (eop),
    .shift_en      (shift_en),
    .rcv_bit       (rcv_bit),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_byte_cnt   (rx_byte_cnt),
    .pid           (pid),
    .pkt_type      (pkt_type),
    .rcving        (rcving),
    .pkt_done      (pkt_done),
    .pkt_ok        (pkt_ok),
    .err_code      (err_code)
  );

  typedef struct packed {
    logic [2:0] err;
    logic [1:0] typ;
    logic [3:0] pid;
    logic [3:0] cnt;
  } pkt_exp_t;

  logic [7:0] exp_bytes[$];
  pkt_exp_t   exp_pkts[$];
  int         tests_run    = 0;
  int         tests_failed = 0;

  logic [7:0] tx[0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a strobe.
  initial begin : monitor
    logic [7:0] b;
    pkt_exp_t   e;
    forever begin
      @(posedge clk);
      #1;
      if (rx_byte_valid) begin
        if (exp_bytes.size() == 0) check("unexpected rx_byte_valid", 32'(rx_byte_valid), 32'd0);
        else begin
          b = exp_bytes.pop_front();
          check("rx_byte", 32'(rx_byte), 32'(b));
        end
      end
      if (pkt_done) begin
        if (exp_pkts.size() == 0) check("unexpected pkt_done", 32'(pkt_done), 32'd0);
        else begin
          e = exp_pkts.pop_front();
          check("err_code",    32'(err_code),    32'(e.err));
          check("pkt_ok",      32'(pkt_ok),      32'(e.err == 3'd0));
          check("pkt_type",    32'(pkt_type),    32'(e.typ));
          check("pid",         32'(pid),         32'(e.pid));
          check("rx_byte_cnt", 32'(rx_byte_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "bench stopped by watchdog");
  end

  function automatic logic [15:0] token_body(input logic [6:0] addr, input logic [3:0] endp);
    logic [10:0] d;
    logic [4:0]  c;
    logic [15:0] body;
    d = {endp, addr};
    c = 5'h1F;
    for (int i = 0; i < 11; i++)
      c = {c[3:0], 1'b0} ^ ((c[4] ^ d[i]) ? 5'h05 : 5'h00);
    body[10:0] = d;
    for (int i = 0; i < 5; i++) body[11+i] = ~c[4-i];
    return body;
  endfunction

  // Payload first+i for n bytes, followed by the complemented CRC16 sent MSB-first.
  task automatic build_data(input int n, input logic [7:0] first);
    logic [15:0] c, field;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      tx[i] = first + 8'(i);
      for (int j = 0; j < 8; j++)
        c = {c[14:0], 1'b0} ^ ((c[15] ^ tx[i][j]) ? 16'h8005 : 16'h0000);
    end
    for (int i = 0; i < 16; i++) field[i] = ~c[15-i];
    tx[n]   = field[7:0];
    tx[n+1] = field[15:8];
  endtask

  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) exp_bytes.push_back(tx[i]);
  endtask

  task automatic expect_pkt(input logic [2:0] err, input logic [1:0] typ,
                            input logic [3:0] p, input logic [3:0] cnt);
    pkt_exp_t e;
    e.err = err; e.typ = typ; e.pid = p; e.cnt = cnt;
    exp_pkts.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk); shift_en = 1'b1; rcv_bit = b;
    @(negedge clk); shift_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_tx(input int n);
    for (int i = 0; i < n; i++) send_byte(tx[i]);
  endtask

  task automatic start_pkt(input logic [7:0] p);
    @(negedge clk); d_edge = 1'b1;
    @(negedge clk); d_edge = 1'b0;
    send_byte(8'b1000_0000);
    send_byte(p);
  endtask

  task automatic end_pkt();
    @(negedge clk); eop = 1'b1;
    @(negedge clk); eop = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin : stimulus
    logic [15:0] tb_tok;
    rst = 1'b1; d_edge = 1'b0; eop = 1'b0; shift_en = 1'b0; rcv_bit = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rcving",        32'(rcving),        32'd0);
    check("reset rx_byte_valid", 32'(rx_byte_valid), 32'd0);
    check("reset pkt_done",      32'(pkt_done),      32'd0);
    check("reset pid",           32'(pid),           32'd0);
    check("reset rx_byte_cnt",   32'(rx_byte_cnt),   32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Token OUT addr 3A endp 1
    tb_tok = token_body(7'h3A, 4'h1);
    exp_bytes.push_back(tb_tok[7:0]);
    exp_bytes.push_back(tb_tok[15:8]);
    expect_pkt(3'd0, 2'd1, 4'h1, 4'd2);
    start_pkt(8'hE1);
    send_byte(tb_tok[7:0]);
    send_byte(tb_tok[15:8]);
    end_pkt();

    // DATA0 01..08
    build_data(8, 8'h01);
    push_bytes(10);
    expect_pkt(3'd0, 2'd3, 4'h3, 4'd10);
    start_pkt(8'hC3);
    send_tx(10);
    end_pkt();

    // ACK
    expect_pkt(3'd0, 2'd2, 4'h2, 4'd0);
    start_pkt(8'hD2);
    end_pkt();

    // Bad PID check; pid/pkt_type still hold the ACK
    expect_pkt(3'd2, 2'd2, 4'h2, 4'd0);
    start_pkt(8'hC2);
    end_pkt();

    // DATA0 with a corrupted CRC16 bit
    build_data(8, 8'h01);
    tx[8][3] = ~tx[8][3];
    push_bytes(10);
    expect_pkt(3'd3, 2'd3, 4'h3, 4'd10);
    start_pkt(8'hC3);
    send_tx(10);
    end_pkt();

    // eop after 13 body bits
    exp_bytes.push_back(8'hA5);
    expect_pkt(3'd4, 2'd3, 4'h3, 4'd1);
    start_pkt(8'hC3);
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    end_pkt();

    // Overflow: 9 payload bytes, error on the 11th byte, then ACK accepted
    build_data(9, 8'h10);
    push_bytes(10);
    expect_pkt(3'd5, 2'd3, 4'hB, 4'd10);
    start_pkt(8'h4B);
    send_tx(11);
    end_pkt();
    expect_pkt(3'd0, 2'd2, 4'h2, 4'd0);
    start_pkt(8'hD2);
    end_pkt();

    // Timeout mid-body
    exp_bytes.push_back(8'h11);
    exp_bytes.push_back(8'h22);
    expect_pkt(3'd6, 2'd3, 4'h3, 4'd2);
    start_pkt(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (200) @(negedge clk);
    check("rcving during stall", 32'(rcving), 32'd1);
    repeat (100) @(negedge clk);
    check("rcving after timeout",   32'(rcving),          32'd0);
    check("timeout pkt reported",   32'(exp_pkts.size()), 32'd0);

    // Reset mid-DATA aborts silently
    exp_bytes.push_back(8'h33);
    exp_bytes.push_back(8'h44);
    start_pkt(8'hC3);
    send_byte(8'h33);
    send_byte(8'h44);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst rcving",        32'(rcving),        32'd0);
    check("rst pid",           32'(pid),           32'd0);
    check("rst pkt_type",      32'(pkt_type),      32'd0);
    check("rst rx_byte_cnt",   32'(rx_byte_cnt),   32'd0);
    check("rst rx_byte",       32'(rx_byte),       32'd0);
    check("rst pkt_ok",        32'(pkt_ok),        32'd0);
    check("rst err_code",      32'(err_code),      32'd0);
    check("rst pkt_done",      32'(pkt_done),      32'd0);
    end_pkt();

    repeat (10) @(negedge clk);
    check("byte queue drained", 32'(exp_bytes.size()), 32'd0);
    check("pkt queue drained",  32'(exp_pkts.size()),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/usb_rx_pkt_ctrl.md
Name: usb_rx_pkt_ctrl

Overview:
Parametrised successor to the fixed token/data/handshake receive controller. Decodes any USB packet type from its PID instead of walking a hard-wired token→data→handshake sequence. Counts bits internally and performs real CRC5/CRC16 residual checks. Streams body bytes to the downstream FIFO and reports per-packet status (ok/error code), with an inactivity timeout.

Parameters:
MAX_DATA_BYTES, 8, maximum data-packet payload in bytes, excluding the 2 CRC16 bytes.
SYNC_PATTERN, 8'b10000000, expected sync byte after LSB-first shift-in.
TIMEOUT_CYCLES, 256, clk cycles without shift_en before a packet is aborted.
CHECK_CRC, 1, 1 = CRC residual failure is an error; 0 = CRC computed and reported but never errors.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
d_edge  in  1  line-activity edge detected (start of packet)
eop  in  1  end-of-packet detected
shift_en  in  1  one decoded, de-stuffed bit valid this cycle
rcv_bit  in  1  decoded bit value
rx_byte  out  8  completed body byte
rx_byte_valid  out  1  one-cycle strobe per rx_byte
rx_byte_cnt  out  $clog2(MAX_DATA_BYTES+3)  body bytes received in the current packet
pid  out  4  low nibble of the accepted PID, held until the next PID is accepted
pkt_type  out  2  0 special, 1 token, 2 handshake, 3 data
rcving  out  1  high in SYNC, PID and BODY
pkt_done  out  1  one-cycle strobe at packet completion
pkt_ok  out  1  valid with pkt_done
err_code  out  3  valid with pkt_done: 0 none, 1 sync, 2 pid, 3 crc, 4 align, 5 overflow, 6 timeout, 7 unsupported

Behaviour:
- Reset: state IDLE; all outputs 0; counters and shift registers cleared. Reset mid-packet aborts silently, with no pkt_done.
- Shift register: shifts right; rcv_bit enters the MSB on shift_en. A 3-bit bit counter wraps every 8 bits.
- States: IDLE, SYNC, PID, BODY, EOP_WAIT, ERR_WAIT.
- IDLE: d_edge → SYNC; clear counters and CRCs.
- SYNC: after 8 bits, byte == SYNC_PATTERN → PID; otherwise err 1 → ERR_WAIT.
- PID: after 8 bits, check pid[7:4] == ~pid[3:0]; failure gives err 2.
  - pid[1:0]: 01 → token; 11 → data; 10 → handshake → EOP_WAIT; 00 → err 7.
  - Token and data go to BODY.
- BODY: each completed byte is driven onto rx_byte with rx_byte_valid on the cycle after the 8th bit, and rx_byte_cnt increments.
  - CRC bits are emitted as bytes too; the consumer drops the last 2.
  - Token: after 16 bits → EOP_WAIT.
  - Data: runs until eop. rx_byte_cnt > MAX_DATA_BYTES+2 → err 5 immediately.
- CRC: CRC5 (poly 0x05, seed 5'h1F) covers the token body. CRC16 (poly 0x8005, seed 16'hFFFF) covers the data body.
  - The check is on the residual after all bits: CRC5 5'b01100, CRC16 16'h800D.
  - Mismatch gives err 3 when CHECK_CRC = 1.
- EOP handling:
  - eop in BODY (data) with bit counter ≠ 0 → err 4.
  - eop in BODY (data) with rx_byte_cnt < 2 → err 4.
  - Otherwise eop in BODY (data) → CRC check → pkt_done.
  - eop in SYNC/PID, or in a token BODY before 16 bits → err 4.
  - EOP_WAIT: eop → pkt_done (ok unless CRC fail).
  - EOP_WAIT: a shift_en before eop → err 4.
- pkt_done: asserted the cycle after eop is sampled. pkt_ok = (err_code == 0). FSM returns to IDLE in the same transition.
- ERR_WAIT: pkt_done with pkt_ok = 0 and err_code is issued on entry. The FSM ignores bits until eop, then → IDLE.
- Timeout: a cycle counter runs in SYNC/PID/BODY/EOP_WAIT and is cleared by shift_en. Reaching TIMEOUT_CYCLES gives err 6 → IDLE, skipping ERR_WAIT.
- Simultaneous events:
  - eop with shift_en in the same cycle: eop wins; the bit is dropped.
  - d_edge outside IDLE is ignored.
  - The first error wins; later errors in the same packet are suppressed.

Decomposition:
- Package usb_rx_pkg: state enum, pkt_type enum, err_code enum, CRC polys/seeds/residuals, SYNC default.
- Sub-module usb_crc_serial: parameters WIDTH, POLY, SEED; ports clk, rst, clr, en, bit_in, crc, residual_ok. Instantiated twice (5-bit and 16-bit).

Test Plan:
- Token OUT: sync, PID 8'hE1, addr 7'h3A, endp 4'h1, model-computed CRC5 → pkt_done, pkt_ok = 1, pkt_type = 1, pid = 4'h1, rx_byte_cnt = 2.
- DATA0: PID 8'hC3, payload 8'h01..8'h08, correct CRC16 → 10 rx_byte_valid strobes in order, pkt_ok = 1, rx_byte_cnt = 10.
- ACK: PID 8'hD2 then eop → pkt_ok = 1, pkt_type = 2, no rx_byte_valid.
- Errors:
  - PID 8'hC2 → err_code 2.
  - DATA0 with CRC16 bit 3 flipped → err_code 3.
  - eop after 13 body bits → err_code 4.
- Overflow: 9 payload bytes with MAX_DATA_BYTES = 8 → err_code 5 on the 11th byte. Waits for eop, then a following ACK is accepted.
- Timeout and reset:
  - Stall 256 cycles mid-body → err_code 6 and rcving = 0.
  - rst asserted mid-DATA → all outputs 0 next cycle and no pkt_done.
